fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between instruction fetch and `instruction_decoder`. It stores `fetched_instruction` entries in order and presents the oldest entry to the decoder. It releases entries only once the macro-op they belong to has fully arrived, unless the queue is full. A front-end flush (branch mispredict or redirect) discards its whole contents in one cycle.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of occupancy counters.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all entries at this edge.
- `in_valid`  in  1  fetch presents `in_instr`.
- `in_ready`  out  1  queue accepts `in_instr` this cycle.
- `in_instr`  in  `fetched_instruction`  instruction word, branch_tag, macroop_start, macroop_end.
- `out_valid`  out  1  head entry is offered to the decoder.
- `out_ready`  in  1  decoder consumes the head this cycle.
- `out_instr`  out  `fetched_instruction`  head entry, driven straight from storage.
- `count`  out  `CNT_W`  current occupancy.

## Operation
- Storage is a circular array of `DEPTH` entries with head and tail pointers of width `$clog2(DEPTH)`. Pointers wrap modulo `DEPTH`.
- `count` tracks occupancy. `end_cnt` counts stored entries with `macroop_end=1`.
- Push fires when `in_valid && in_ready`. The entry is written at tail, tail increments, and `count` increments. `end_cnt` also increments if `in_instr.macroop_end` is set.
- Pop fires when `out_valid && out_ready`. Head increments and `count` decrements. `end_cnt` also decrements if the head entry has `macroop_end` set.
- Push and pop in the same cycle: `count` is unchanged. `end_cnt` changes by the net difference of the two terms.
- `in_ready = !full && !flush`, where `full = (count == DEPTH)`. There is no pop-through when full.
- `out_valid = (count != 0) && (end_cnt != 0 || full) && !flush`.
  - The head is released only once a macro-op end is queued, so the decoder sees complete macro-ops back-to-back.
  - The full override prevents deadlock on a macro-op longer than `DEPTH`.
- Flush has priority over push and pop in the same cycle. Next state: head = tail = 0, `count` = 0, `end_cnt` = 0.
- Entries are never reordered or modified. `branch_tag` and the macroop flags pass through bit-exact.
- Reset gives the same state as flush. Storage contents are not cleared.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `count` = 0.
  - `out_instr` is don't-care while `out_valid` = 0.
- Latency: an entry pushed at edge N can first appear with `out_valid` = 1 in the cycle after edge N. This requires its macro-op end to be present, or the queue to be full.
- There is no same-cycle bypass from `in_instr` to `out_instr`.
- `out_valid` and `in_ready` are combinational from registered state and `flush` only. They do not depend on `in_valid` or `out_ready`, so there are no combinational loops with neighbouring stages.
- Throughput: one push and one pop per cycle in steady state.
- If `flush` and `rst` are asserted together, reset takes effect; the result is identical.
- Reset or flush mid-macro-op: a partial macro-op is discarded. Fetch is responsible for restarting at a macro-op boundary.

## Structure
- `fetched_instruction` stays in the shared instruction package. `TAG_W` for `branch_tag` is defined there as well, not in this block.
- The `end_cnt` and `count` update logic lives in the top module.
- One sub-module is natural: `fifo_mem`, a parameterised `DEPTH`×`$bits(fetched_instruction)` register array. It has one synchronous write port and one asynchronous read port.

## Test plan
1. **Reset, then single-instruction macro-ops.** After reset, push A, B, C, each with start=end=1, with `out_ready`=1. `out_instr` shows A, B, C on consecutive cycles, and the first `out_valid` rises the cycle after A is pushed. `count` peaks at 1.
2. **Macro-op gating.** Push X (start=1, end=0), hold 3 idle cycles, then push Y (end=1). `out_valid` stays 0 until the cycle after Y is pushed. X and then Y pop on consecutive cycles.
3. **Full with no end present.** `DEPTH`=8; push 8 entries, all with end=0, and hold `out_ready`=0.
   - `in_ready` = 0 and `count` = 8.
   - `out_valid` = 1 through the full override.
   - Pop one: `in_ready` returns to 1 and `out_valid` drops to 0.
4. **Simultaneous push and pop at wrap.** Fill to 7 entries, then run 20 cycles with both push and pop every cycle. `count` stays 7, pointers wrap at least twice, and output order matches input order exactly.
5. **Flush priority.** With 5 entries queued, assert `flush` in the same cycle as `in_valid`=1 and `out_ready`=1. `in_ready` = `out_valid` = 0 in that cycle. Next cycle `count` = 0, and the flushed-cycle input is not stored.
6. **Pass-through integrity.** Push random instruction words carrying all `branch_tag` values and all flag combinations, checked against a scoreboard. Popped entries match bit-exactly, with no loss or duplication.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared instruction-side types used by the fetch queue and its neighbours.
package fetch_queue_pkg;

    // Width of the branch tag carried with every fetched instruction.
    localparam int unsigned TAG_W   = 4;
    // Width of a raw instruction word.
    localparam int unsigned INSTR_W = 32;

    // One fetched instruction as it travels from fetch to the decoder.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [TAG_W-1:0]   branch_tag;
        logic               macroop_start;
        logic               macroop_end;
    } fetched_instruction;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner.
module fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry on a qualified write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order decoupling buffer between fetch and the instruction decoder.
// The head is only offered once a complete macro-op is queued (or the queue is full),
// and a front-end flush empties the queue in a single cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  fetched_instruction in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output fetched_instruction out_instr,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = $bits(fetched_instruction);

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_end_cnt;

    logic [PTR_W-1:0]   w_head_d;
    logic [PTR_W-1:0]   w_tail_d;
    logic [CNT_W-1:0]   w_count_d;
    logic [CNT_W-1:0]   w_end_cnt_d;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_push_end;
    logic               w_pop_end;
    logic [ENTRY_W-1:0] w_rd_data;

    // Handshakes depend only on registered state and flush, never on in_valid/out_ready.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign in_ready  = !w_full && !flush;
    // Full override keeps a macro-op longer than the queue from deadlocking.
    assign out_valid = (r_count != '0) && ((r_end_cnt != '0) || w_full) && !flush;

    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_push_end = w_push && in_instr.macroop_end;
    assign w_pop_end  = w_pop && out_instr.macroop_end;

    assign out_instr = fetched_instruction'(w_rd_data);
    assign count     = r_count;

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .ADDR_W(PTR_W)
    ) u_fifo_mem (
        .i_clk  (clk),
        .i_we   (w_push),
        .i_waddr(r_tail),
        .i_wdata(in_instr),
        .i_raddr(r_head),
        .o_rdata(w_rd_data)
    );

    // Next-state for pointers, occupancy and the count of queued macro-op ends.
    always_comb begin
        w_head_d    = r_head;
        w_tail_d    = r_tail;
        w_count_d   = r_count;
        w_end_cnt_d = r_end_cnt;

        // Pointers are power-of-two wide, so the add wraps modulo DEPTH.
        if (w_push) begin
            w_tail_d = r_tail + PTR_W'(1);
        end
        if (w_pop) begin
            w_head_d = r_head + PTR_W'(1);
        end

        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase

        unique case ({w_push_end, w_pop_end})
            2'b10:   w_end_cnt_d = r_end_cnt + CNT_W'(1);
            2'b01:   w_end_cnt_d = r_end_cnt - CNT_W'(1);
            default: w_end_cnt_d = r_end_cnt;
        endcase
    end

    // State register; reset and flush both return to empty, storage untouched.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_end_cnt <= '0;
        end else begin
            r_head    <= w_head_d;
            r_tail    <= w_tail_d;
            r_count   <= w_count_d;
            r_end_cnt <= w_end_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed sequences plus a scoreboard checker.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    fetched_instruction in_instr;
    logic               out_valid;
    logic               out_ready;
    fetched_instruction out_instr;
    logic [CNT_W-1:0]   count;

    int n_vec = 0;
    int n_err = 0;

    fetched_instruction sb[$];
    int                 m_count = 0;
    int                 m_end   = 0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required bench completion");
        $fatal(1, "bench did not complete");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic fetched_instruction mk(input logic [31:0] w, input logic [3:0] tag,
                                              input logic s, input logic e);
        fetched_instruction f;
        f.instr         = w;
        f.branch_tag    = tag;
        f.macroop_start = s;
        f.macroop_end   = e;
        return f;
    endfunction

    // Drive one cycle's inputs just after the edge, then wait for the sampling point.
    task automatic cyc(input logic v, input fetched_instruction d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
    endtask

    // Scoreboard checker: expected handshakes from the model, popped data against the queue.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_count = 0;
            m_end   = 0;
        end else begin
            automatic logic exp_ir = !flush && (m_count != DEPTH);
            automatic logic exp_ov = !flush && (m_count != 0) && (m_end != 0 || m_count == DEPTH);
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("count", 64'(count), 64'(m_count));
            if (flush) begin
                sb.delete();
                m_count = 0;
                m_end   = 0;
            end else begin
                if (exp_ov && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        automatic fetched_instruction e = sb.pop_front();
                        check("out_instr", 64'(out_instr), 64'(e));
                        if (e.macroop_end) m_end--;
                    end
                    m_count--;
                end
                if (exp_ir && in_valid) begin
                    sb.push_back(in_instr);
                    if (in_instr.macroop_end) m_end++;
                    m_count++;
                end
            end
        end
    end

    initial begin
        fetched_instruction a, b, c, x, y, first, z, w;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and single-instruction macro-ops.
        a = mk(32'hA000_0001, 4'h1, 1'b1, 1'b1);
        b = mk(32'hB000_0002, 4'h2, 1'b1, 1'b1);
        c = mk(32'hC000_0003, 4'h3, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        cyc(1'b1, a, 1'b1, 1'b0);
        check("t1_no_bypass", 64'(out_valid), 64'(0));
        cyc(1'b1, b, 1'b1, 1'b0);
        check("t1_a_valid", 64'(out_valid), 64'(1));
        check("t1_a_data", 64'(out_instr), 64'(a));
        cyc(1'b1, c, 1'b1, 1'b0);
        check("t1_b_data", 64'(out_instr), 64'(b));
        check("t1_b_count", 64'(count), 64'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_c_data", 64'(out_instr), 64'(c));
        check("t1_c_count", 64'(count), 64'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_empty_ov", 64'(out_valid), 64'(0));
        check("t1_empty_count", 64'(count), 64'(0));

        // Macro-op gating: X held until its end Y arrives.
        x = mk(32'h1111_0000, 4'h4, 1'b1, 1'b0);
        y = mk(32'h2222_0000, 4'h5, 1'b0, 1'b1);
        cyc(1'b1, x, 1'b1, 1'b0);
        check("t2_push_x_ov", 64'(out_valid), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            check("t2_gated_ov", 64'(out_valid), 64'(0));
            check("t2_gated_count", 64'(count), 64'(1));
        end
        cyc(1'b1, y, 1'b1, 1'b0);
        check("t2_push_y_ov", 64'(out_valid), 64'(0));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t2_x_ov", 64'(out_valid), 64'(1));
        check("t2_x_data", 64'(out_instr), 64'(x));
        check("t2_x_count", 64'(count), 64'(2));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t2_y_data", 64'(out_instr), 64'(y));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t2_drained", 64'(count), 64'(0));

        // Full with no macro-op end queued.
        first = mk(32'h3000_0000, 4'h6, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, mk(32'h3000_0000 + 32'(i), 4'h6, (i == 0), 1'b0), 1'b0, 1'b0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t3_full_in_ready", 64'(in_ready), 64'(0));
        check("t3_full_count", 64'(count), 64'(8));
        check("t3_full_ov", 64'(out_valid), 64'(1));
        check("t3_full_head", 64'(out_instr), 64'(first));
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t3_pop_in_ready", 64'(in_ready), 64'(1));
        check("t3_pop_ov", 64'(out_valid), 64'(0));
        check("t3_pop_count", 64'(count), 64'(7));
        cyc(1'b1, mk(32'h3000_00FF, 4'h6, 1'b0, 1'b1), 1'b1, 1'b0);
        repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t3_drained", 64'(count), 64'(0));

        // Simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, mk(32'h4000_0000 + 32'(i), 4'(i), 1'b1, 1'b1), 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, mk(32'h4100_0000 + 32'(i), 4'(i), 1'b1, 1'b1), 1'b1, 1'b0);
            check("t4_steady_count", 64'(count), 64'(7));
        end
        repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t4_drained", 64'(count), 64'(0));

        // Flush priority over push and pop.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, mk(32'h5000_0000 + 32'(i), 4'h7, 1'b1, 1'b1), 1'b0, 1'b0);
        end
        z = mk(32'hDEAD_BEEF, 4'h8, 1'b1, 1'b1);
        w = mk(32'h600D_F00D, 4'h9, 1'b1, 1'b1);
        cyc(1'b1, z, 1'b1, 1'b1);
        check("t5_flush_in_ready", 64'(in_ready), 64'(0));
        check("t5_flush_ov", 64'(out_valid), 64'(0));
        check("t5_flush_count_before", 64'(count), 64'(5));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_after_count", 64'(count), 64'(0));
        check("t5_after_ov", 64'(out_valid), 64'(0));
        cyc(1'b1, w, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_w_ov", 64'(out_valid), 64'(1));
        check("t5_w_data", 64'(out_instr), 64'(w));
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Pass-through integrity: every tag and flag combination.
        for (int t = 0; t < 16; t++) begin
            for (int f = 0; f < 4; f++) begin
                cyc(1'b1, mk($urandom, 4'(t), f[1], f[0]), 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, mk(32'h7700_0000 + 32'(i), 4'hF, 1'b1, 1'b1), 1'b1, 1'b0);
        end
        repeat (20) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t6_drained", 64'(count), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
